// File: rtl/burst_accumulator.sv
// burst_accumulator
//   Control stage wrapped around an external 8-bit combinational adder.
//   Operands arrive over a valid/ready handshake and are summed into an
//   accumulator by routing {acc, in_data} through the adder and registering
//   its sum. At the end of a burst the total, a sticky carry and a saturating
//   beat count are presented on an output valid/ready handshake.
//
//   Optional build macro: BURST_ACC_SAT_EN
//     defined   : the accumulator saturates to 8'hFF on the first carry and
//                 stays there for the rest of the burst.
//     undefined : the accumulator wraps modulo 256; out_carry flags the wrap.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand valid
//   in_ready   operand can be accepted this cycle
//   in_data    operand
//   in_last    final operand of the burst (qualified by in_valid)
//   add_a      adder input a (running accumulator, or 0 on the first beat)
//   add_b      adder input b (incoming operand)
//   add_sum    adder output, no carry-out
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_sum    burst total
//   out_carry  sticky carry out of bit 7 over the burst
//   out_count  beats accepted, saturating at all-ones
module burst_accumulator #(
   parameter int unsigned LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic [7:0]       add_a,
   output logic [7:0]       add_b,
   input  logic [7:0]       add_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_sum,
   output logic             out_carry,
   output logic [LEN_W-1:0] out_count
);

   localparam int unsigned DW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [DW-1:0]   acc;
   logic            carry;
   logic [LEN_W-1:0] count;

   logic             accept;
   logic             step_c;
   logic             carry_nxt;
   logic [DW-1:0]    acc_nxt;
   logic [LEN_W-1:0] count_nxt;

   // Ready is a pure decode of the state register.
   assign in_ready = (state != DONE);
   assign accept   = in_valid & in_ready;

   // Adder operands: first beat of a burst adds to zero.
   always_comb begin
      add_b = in_data;
      add_a = acc;
      if (state == IDLE) begin
         add_a = '0;
      end
   end

   // Carry out of bit 7 recovered from the operand and sum MSBs.
   assign step_c = (add_a[DW-1] & add_b[DW-1]) |
                   ((add_a[DW-1] ^ add_b[DW-1]) & ~add_sum[DW-1]);

   // Values written into the accumulator state on an accepted beat.
   always_comb begin
      carry_nxt = step_c;
      count_nxt = LEN_W'(1);
      if (state == ACC) begin
         carry_nxt = carry | step_c;
         count_nxt = (&count) ? count : count + LEN_W'(1);
      end
`ifdef BURST_ACC_SAT_EN
      acc_nxt = carry_nxt ? {DW{1'b1}} : add_sum;
`else
      acc_nxt = add_sum;
`endif
   end

   // Burst FSM with accumulator and registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         carry     <= 1'b0;
         count     <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_carry <= 1'b0;
         out_count <= '0;
      end else begin
         case (state)
            IDLE, ACC: begin
               if (accept) begin
                  acc   <= acc_nxt;
                  carry <= carry_nxt;
                  count <= count_nxt;
                  if (in_last) begin
                     // Result is published on the same edge as the last beat.
                     state     <= DONE;
                     out_valid <= 1'b1;
                     out_sum   <= acc_nxt;
                     out_carry <= carry_nxt;
                     out_count <= count_nxt;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= '0;
                  carry     <= 1'b0;
                  count     <= '0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_burst_accumulator.sv
// Bench for burst_accumulator: directed bursts, expected results queued at
// stimulus time and checked by an independent output monitor.
module tb_burst_accumulator;

   localparam int unsigned LEN_W = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic             in_last;
   logic [7:0]       add_a;
   logic [7:0]       add_b;
   logic [7:0]       add_sum;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_sum;
   logic             out_carry;
   logic [LEN_W-1:0] out_count;

   typedef struct packed {
      logic [7:0]       sum;
      logic             carry;
      logic [LEN_W-1:0] count;
   } result_t;

   result_t exp_q[$];
   int      checks;
   int      errors;
   bit      sat_build;

   burst_accumulator #(.LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sum   (add_sum),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .out_count (out_count)
   );

   // External adder: 8-bit sum, carry-out dropped.
   assign add_sum = 8'(add_a + add_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [7:0] s, input logic c, input logic [LEN_W-1:0] n);
      result_t r;
      r.sum   = s;
      r.carry = c;
      r.count = n;
      exp_q.push_back(r);
   endtask

   // Present one beat and hold it until accepted; inputs change 1ns after posedge.
   task automatic send(input logic [7:0] d, input logic l);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'(in_ready), 32'd1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (l) begin
         @(negedge clk);
         check("out_valid_latency", 32'(out_valid), 32'd1);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every result handshake pops one expected entry.
   initial begin
      result_t e;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("out_sum",   32'(out_sum),   32'(e.sum));
               check("out_carry", 32'(out_carry), 32'(e.carry));
               check("out_count", 32'(out_count), 32'(e.count));
            end
         end
      end
   end

   initial begin
      int n;
`ifdef BURST_ACC_SAT_EN
      sat_build = 1'b1;
`else
      sat_build = 1'b0;
`endif
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset values.
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum",   32'(out_sum),   32'd0);
      check("rst_out_carry", 32'(out_carry), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_add_a",     32'(add_a),     32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Four-beat burst, back to back.
      push(8'h0A, 1'b0, 4'd4);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      send(8'h04, 1'b1);
      idle_cycles(2);

      // Reset mid-burst clears everything asynchronously.
      send(8'h10, 1'b0);
      send(8'h20, 1'b0);
      check("midburst_add_a", 32'(add_a), 32'h30);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_sum",   32'(out_sum),   32'd0);
      check("arst_out_carry", 32'(out_carry), 32'd0);
      check("arst_out_count", 32'(out_count), 32'd0);
      check("arst_add_a",     32'(add_a),     32'd0);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      push(8'h05, 1'b0, 4'd1);
      send(8'h05, 1'b1);
      idle_cycles(1);

      // Wrap (or saturate) on carry out of bit 7.
      push(sat_build ? 8'hFF : 8'h10, 1'b1, 4'd2);
      send(8'hF0, 1'b0);
      send(8'h20, 1'b1);
      idle_cycles(1);

      // Backpressure: result held, no beat consumed.
      out_ready = 1'b0;
      push(8'h80, 1'b0, 4'd2);
      send(8'h7F, 1'b0);
      send(8'h01, 1'b1);
      push(8'h55, 1'b0, 4'd1);
      in_valid = 1'b1;
      in_data  = 8'h55;
      in_last  = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("bp_in_ready",  32'(in_ready),  32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_sum",   32'(out_sum),   32'h80);
         check("bp_out_count", 32'(out_count), 32'd2);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_no_accept_in_done", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("bp_ready_next_cycle", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      check("bp_second_result", 32'(out_valid), 32'd1);
      idle_cycles(1);

      // Count saturation over 20 beats.
      push(8'h00, 1'b0, 4'hF);
      for (int i = 0; i < 20; i++) begin
         send(8'h00, (i == 19) ? 1'b1 : 1'b0);
      end
      idle_cycles(1);

      // Bubbles: valid pattern 1,0,0,1,0,1.
      push(8'h33, 1'b0, 4'd3);
      send(8'h11, 1'b0);
      idle_cycles(2);
      send(8'h11, 1'b0);
      idle_cycles(1);
      send(8'h11, 1'b1);
      idle_cycles(1);

      // Single-beat burst with MSB set, no carry.
      push(8'hC3, 1'b0, 4'd1);
      send(8'hC3, 1'b1);

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("results_outstanding", 32'(exp_q.size()), 32'd0);
      idle_cycles(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
